// File: rtl/mips_alu_issue.sv
// ID/EX issue register for a MIPS ALU: decodes the ALU opcode, selects and extends
// operands, and registers everything so every output comes straight from a flop.
module mips_alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic        alu_src,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  input  logic [4:0]  rd_in,
  output logic        ex_valid,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  ex_rd,
  output logic        illegal_op
);

  localparam int unsigned DataW = 32;
  localparam int unsigned ImmW  = 16;
  localparam int unsigned CtrlW = 4;

  localparam logic [CtrlW-1:0] CtrlAnd = 4'd0;
  localparam logic [CtrlW-1:0] CtrlOr  = 4'd1;
  localparam logic [CtrlW-1:0] CtrlAdd = 4'd2;
  localparam logic [CtrlW-1:0] CtrlSub = 4'd6;
  localparam logic [CtrlW-1:0] CtrlSlt = 4'd7;
  localparam logic [CtrlW-1:0] CtrlNor = 4'd12;
  localparam logic [CtrlW-1:0] CtrlBad = 4'd15;

  logic [CtrlW-1:0] ctrl_c;
  logic             illegal_c;
  logic [DataW-1:0] imm_ext_c;
  logic [DataW-1:0] in2_c;

  // ALU control decode; unsupported R-type functs map to the null opcode
  always_comb begin
    ctrl_c    = CtrlAdd;
    illegal_c = 1'b0;
    unique case (alu_op)
      2'b00: ctrl_c = CtrlAdd;
      2'b01: ctrl_c = CtrlSub;
      2'b11: ctrl_c = CtrlOr;
      2'b10: begin
        unique case (funct)
          6'b100000: ctrl_c = CtrlAdd;
          6'b100010: ctrl_c = CtrlSub;
          6'b100100: ctrl_c = CtrlAnd;
          6'b100101: ctrl_c = CtrlOr;
          6'b100111: ctrl_c = CtrlNor;
          6'b101010: ctrl_c = CtrlSlt;
          default: begin
            ctrl_c    = CtrlBad;
            illegal_c = 1'b1;
          end
        endcase
      end
      default: ctrl_c = CtrlAdd;
    endcase
  end

  // ori takes a zero-extended immediate, everything else sign-extends
  always_comb begin
    imm_ext_c = {{(DataW-ImmW){imm[ImmW-1]}}, imm};
    if (alu_op == 2'b11) imm_ext_c = {{(DataW-ImmW){1'b0}}, imm};
    in2_c = alu_src ? imm_ext_c : rt_data;
  end

  // rst > flush > stall > load; rst and flush both load the bubble
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid   <= 1'b0;
      alu_ctrl   <= '0;
      in1        <= '0;
      in2        <= '0;
      ex_rd      <= '0;
      illegal_op <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      alu_ctrl   <= ctrl_c;
      in1        <= rs_data;
      in2        <= in2_c;
      ex_rd      <= rd_in;
      illegal_op <= id_valid & illegal_c;
    end
  end

endmodule

// File: doc/mips_alu_issue.md
MIPS_ALU_ISSUE -- requirements
Module: mips_alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- stall  input  1  hold the EX register contents
- flush  input  1  load a bubble into the EX register
- id_valid  input  1  the ID-stage instruction is valid
- alu_op  input  2  main-decoder class: 00 mem/addi, 01 branch, 10 R-type, 11 ori
- funct  input  6  R-type function field
- alu_src  input  1  0 = rt_data, 1 = extended immediate
- rs_data  input  32  register-file operand A
- rt_data  input  32  register-file operand B
- imm  input  16  instruction immediate
- rd_in  input  5  destination register number
- ex_valid  output  1  the EX register holds a valid instruction
- alu_ctrl  output  4  registered ALU opcode
- in1  output  32  registered ALU operand A
- in2  output  32  registered ALU operand B
- ex_rd  output  5  registered destination register
- illegal_op  output  1  the registered instruction has an unsupported funct
REQ-003 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Function
REQ-004 The decode SHALL produce the following alu_ctrl values:
- alu_op 00 -> 2 (ADD)
- alu_op 01 -> 6 (SUB)
- alu_op 11 -> 1 (OR)
- alu_op 10 uses funct: 100000 -> 2, 100010 -> 6, 100100 -> 0, 100101 -> 1, 100111 -> 12, 101010 -> 7
REQ-005 An R-type instruction with any other funct SHALL decode to alu_ctrl=15 and illegal_op=1. The ALU then outputs 0 for that opcode.
REQ-006 illegal_op SHALL be 0 for alu_op 00, 01 and 11, regardless of funct.
REQ-007 The immediate extension SHALL be a zero-extension ({16'h0,imm}) when alu_op=11 and a sign-extension ({{16{imm[15]}},imm}) otherwise.
REQ-008 The next in1 value SHALL be rs_data. The next in2 value SHALL be the extended immediate if alu_src=1, else rt_data.
REQ-009 Load: on each rising clk edge with rst=0, flush=0 and stall=0, the register SHALL capture ex_valid=id_valid together with the decoded alu_ctrl, in1, in2, ex_rd and illegal_op. The latency is exactly 1 cycle.
REQ-010 An instruction captured with id_valid=0 SHALL still load its decoded fields, but with ex_valid=0 and illegal_op forced to 0.
REQ-011 Stall: when stall=1 (and rst=0, flush=0), every output register SHALL hold its value, including ex_valid. The hold is unlimited in duration.
REQ-012 Flush: when flush=1 (and rst=0), the register SHALL load the bubble state defined in REQ-015. Flush has priority over stall.
REQ-013 Priority SHALL be rst > flush > stall > load. Simultaneous flush and stall therefore yields a bubble.
REQ-014 Operand arithmetic SHALL be pure bit selection and extension, with no truncation or carry. imm=16'h8000 SHALL yield 32'hFFFF8000 when sign-extended and 32'h00008000 when zero-extended.

Reset
REQ-015 On a rising clk edge with rst=1, the outputs SHALL become ex_valid=0, alu_ctrl=0, in1=0, in2=0, ex_rd=0, illegal_op=0. This bubble state is also what flush loads.
REQ-016 Reset SHALL override stall and flush on the same edge, and SHALL abandon any held (stalled) instruction.
REQ-017 On the first edge after rst deasserts, normal loading SHALL resume with no extra idle cycle.
REQ-018 Before the first clk edge, with rst asserted, output values are unspecified. Reset is not asynchronous.

Verification
REQ-019 R-type add: alu_op=10, funct=100000, rs_data=5, rt_data=7, alu_src=0, id_valid=1 -> next cycle alu_ctrl=2, in1=5, in2=7, ex_valid=1, illegal_op=0.
REQ-020 addi with negative immediate: alu_op=00, alu_src=1, imm=16'hFFFC, rs_data=32'h10 -> alu_ctrl=2, in2=32'hFFFFFFFC. ori with imm=16'hFFFC -> alu_ctrl=1, in2=32'h0000FFFC.
REQ-021 Funct sweep: all six legal functs -> alu_ctrl 2, 6, 0, 1, 12, 7 respectively. funct=000000 with alu_op=10 -> alu_ctrl=15, illegal_op=1. The same funct with alu_op=01 -> alu_ctrl=6, illegal_op=0.
REQ-022 Stall/flush: load an sub instruction, then assert stall for 3 cycles while the inputs change -> outputs stay constant. Asserting stall and flush together -> the bubble state of REQ-015 on the next edge.
REQ-023 Reset mid-stall: with a valid instruction held by stall=1, assert rst for 1 cycle -> the bubble state of REQ-015. Releasing rst with id_valid=1 -> the new instruction appears 1 cycle later.
